// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the front end of the single-cycle-decode pipeline:
//   - major opcode constants used by the decoder
//   - the bubble instruction (sll $0,$0,0)
//   - fetch FSM state encoding
//   - PC increment and a word-alignment helper
package mips_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [5:0]  OP_SW    = 6'b101011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  // Instruction addresses are always word aligned; drop the byte offset.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf
// Single-entry {instr, pc} holding register. Catches a word that memory
// acknowledged while the downstream stage was stalled, so it is not lost.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_load     capture i_data, mark full
//   i_unload   entry consumed, mark empty
//   i_clear    discard entry (flush); wins over load/unload
//   i_data     {instr[31:0], pc[31:0]}
//   o_data     stored entry
//   o_full     entry holds a valid word
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [63:0] i_data,
  output logic [63:0] o_data,
  output logic        o_full
);

  logic [63:0] r_data;
  logic        r_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_clear) begin
        r_full <= 1'b0;
      end else if (i_load) begin
        r_data <= i_data;
        r_full <= 1'b1;
      end else if (i_unload) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Fetch stage: owns the PC, runs the req/ack handshake to instruction
// memory and registers the fetched word into the IF/ID register that
// feeds the control decoder. Handles downstream stall (via a one-entry
// skid buffer) and branch redirect/flush.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   imem_req      fetch request (S_REQ only)
//   imem_addr     fetch address, stable while a request is outstanding
//   imem_ack      memory returns imem_rdata this cycle
//   imem_rdata    fetched instruction
//   stall         downstream cannot accept; IF/ID holds
//   redirect      branch taken: flush and refetch from redirect_pc
//   redirect_pc   redirect target (low two bits ignored)
//   instrWord     IF/ID instruction, NOP_WORD when not valid
//   pc_out        PC of instrWord
//   pc_plus4      pc_out + 4
//   if_valid      instrWord holds a real instruction
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instrWord,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        if_valid
);

  import mips_pkg::fetch_state_e;
  import mips_pkg::S_IDLE;
  import mips_pkg::S_REQ;
  import mips_pkg::S_HOLD;
  import mips_pkg::PC_INC;
  import mips_pkg::word_align;

  fetch_state_e r_state, w_state_next;
  logic [31:0]  r_pc, w_pc_next;
  // r_kill: an outstanding request was overtaken by a redirect; its ack
  // must be thrown away. r_old_addr keeps that request's address on the
  // bus while r_pc already holds the redirect target.
  logic         r_kill, w_kill_next;
  logic [31:0]  r_old_addr, w_old_addr_next;
  logic [31:0]  r_instr, w_instr_next;
  logic [31:0]  r_pc_out, w_pc_out_next;
  logic [31:0]  r_pc_plus4, w_pc_plus4_next;
  logic         r_valid, w_valid_next;

  logic         w_skid_load, w_skid_unload, w_skid_clear, w_skid_full;
  logic [63:0]  w_skid_data;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_inc;
  logic [31:0]  w_skid_pc;

  assign w_target  = word_align(redirect_pc);
  assign w_pc_inc  = r_pc + PC_INC;
  assign w_skid_pc = w_skid_data[31:0];

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_skid_clear),
    .i_data   ({imem_rdata, r_pc}),
    .o_data   (w_skid_data),
    .o_full   (w_skid_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_old_addr <= RESET_PC;
      r_instr    <= NOP_WORD;
      r_pc_out   <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_kill     <= w_kill_next;
      r_old_addr <= w_old_addr_next;
      r_instr    <= w_instr_next;
      r_pc_out   <= w_pc_out_next;
      r_pc_plus4 <= w_pc_plus4_next;
      r_valid    <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_kill_next     = r_kill;
    w_old_addr_next = r_old_addr;
    w_instr_next    = r_instr;
    w_pc_out_next   = r_pc_out;
    w_pc_plus4_next = r_pc_plus4;
    w_valid_next    = r_valid;
    w_skid_load     = 1'b0;
    w_skid_unload   = 1'b0;
    w_skid_clear    = 1'b0;
    imem_req        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_state_next = S_REQ;
        if (redirect) begin
          w_pc_next    = w_target;
          w_instr_next = NOP_WORD;
          w_valid_next = 1'b0;
        end
      end

      S_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          w_pc_next    = w_target;
          w_instr_next = NOP_WORD;
          w_valid_next = 1'b0;
          if (imem_ack) begin
            w_kill_next = 1'b0;
          end else begin
            // Keep the bus on the original address; a second redirect
            // only replaces the target in r_pc.
            if (!r_kill) w_old_addr_next = r_pc;
            w_kill_next = 1'b1;
          end
        end else if (imem_ack && r_kill) begin
          w_kill_next = 1'b0;
          if (!stall) begin
            w_instr_next = NOP_WORD;
            w_valid_next = 1'b0;
          end
        end else if (imem_ack && !stall) begin
          w_instr_next    = imem_rdata;
          w_pc_out_next   = r_pc;
          w_pc_plus4_next = w_pc_inc;
          w_valid_next    = 1'b1;
          w_pc_next       = w_pc_inc;
        end else if (imem_ack) begin
          w_skid_load  = 1'b1;
          w_pc_next    = w_pc_inc;
          w_state_next = S_HOLD;
        end else if (!stall) begin
          w_instr_next = NOP_WORD;
          w_valid_next = 1'b0;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          w_skid_clear = 1'b1;
          w_pc_next    = w_target;
          w_instr_next = NOP_WORD;
          w_valid_next = 1'b0;
          w_state_next = S_REQ;
        end else if (!stall) begin
          if (w_skid_full) begin
            w_instr_next    = w_skid_data[63:32];
            w_pc_out_next   = w_skid_pc;
            w_pc_plus4_next = w_skid_pc + PC_INC;
            w_valid_next    = 1'b1;
          end
          w_skid_unload = 1'b1;
          w_state_next  = S_REQ;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign imem_addr = r_kill ? r_old_addr : r_pc;
  assign instrWord = r_instr;
  assign pc_out    = r_pc_out;
  assign pc_plus4  = r_pc_plus4;
  assign if_valid  = r_valid;

endmodule
